fnd_ascii_sender: RTL

Takes the 4-digit BCD word that the display path produces (time HH:MM / SS:msec, or sensor value) and sends it over the UART transmitter as an ASCII text frame.
- On a send request it latches the word, builds the frame and hands bytes one at a time to the UART TX through a start/busy handshake.
- It is the outbound (reader) end of the 16-bit display-data interface. Sits between the FND controller's display_data and the UART TX core.

---
 rtl/fnd_ascii_sender_pkg.sv | 22 ++
 rtl/fnd_ascii_sender_bcd_to_ascii.sv | 15 +
 rtl/fnd_ascii_sender.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fnd_ascii_sender_pkg.sv
// Shared definitions for the BCD-to-UART ASCII frame sender:
// FSM state encoding, ASCII byte constants and frame lengths.
package fnd_ascii_sender_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  localparam int unsigned FRAME_LEN_CRLF  = 7;
  localparam int unsigned FRAME_LEN_PLAIN = 5;

endpackage

// File: rtl/fnd_ascii_sender_bcd_to_ascii.sv
// Converts one BCD digit to its ASCII character; non-decimal nibbles
// (10..15) render as '-'.
module bcd_to_ascii
  import fnd_ascii_sender_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] ascii
);

  always_comb begin
    if (bcd > 4'd9) ascii = ASCII_DASH;
    else            ascii = ASCII_ZERO + {4'h0, bcd};
  end

endmodule

// File: rtl/fnd_ascii_sender.sv
// Latches a 4-digit BCD display word and streams it to a UART TX as an
// ASCII frame "d3 d2 SEP d1 d0 [CR LF]" over a start/busy handshake.
module fnd_ascii_sender
  import fnd_ascii_sender_pkg::*;
#(
  parameter bit         SEND_CRLF  = 1'b1,
  parameter logic [7:0] SEP_TIME   = ASCII_COLON,
  parameter logic [7:0] SEP_SENSOR = ASCII_DOT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_send,
  input  logic [15:0] i_bcd_data,
  input  logic        i_mode,
  input  logic        i_tx_busy,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned FRAME_LEN = SEND_CRLF ? FRAME_LEN_CRLF : FRAME_LEN_PLAIN;
  localparam logic [2:0]  LAST_IDX  = 3'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic        mode_q, mode_d;
  logic        start_d, busy_d, done_d;
  logic [7:0]  txd_d;

  logic [3:0]  nibble;
  logic [7:0]  digit_ascii;
  logic [7:0]  frame_byte;

  always_comb begin
    case (idx_q)
      3'd0:    nibble = data_q[15:12];
      3'd1:    nibble = data_q[11:8];
      3'd3:    nibble = data_q[7:4];
      default: nibble = data_q[3:0];
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .bcd   (nibble),
    .ascii (digit_ascii)
  );

  always_comb begin
    case (idx_q)
      3'd2:    frame_byte = mode_q ? SEP_SENSOR : SEP_TIME;
      3'd5:    frame_byte = ASCII_CR;
      3'd6:    frame_byte = ASCII_LF;
      default: frame_byte = digit_ascii;
    endcase
  end

  // A request in the o_done cycle is dropped: the frame is still
  // finishing from the requester's point of view.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    txd_d   = o_tx_data;
    busy_d  = o_busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_send && !o_done) begin
          data_d  = i_bcd_data;
          mode_d  = i_mode;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!i_tx_busy) begin
          start_d = 1'b1;
          txd_d   = frame_byte;
          state_d = GAP;
        end
      end
      GAP: state_d = WAIT;
      WAIT: begin
        if (!i_tx_busy) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      o_tx_start <= start_d;
      o_tx_data  <= txd_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

endmodule
